// File: rtl/watch_pkg.sv
// Shared types and helpers for the watch setting-mode controller.
// State encoding, field_sel codes and counter width sizing.
package watch_pkg;

   typedef enum logic [1:0] {
      StRun     = 2'b00,
      StSetSec  = 2'b01,
      StSetMin  = 2'b10,
      StSetHour = 2'b11
   } state_t;

   localparam logic [1:0] FIELD_NONE = 2'b00;
   localparam logic [1:0] FIELD_SEC  = 2'b01;
   localparam logic [1:0] FIELD_MIN  = 2'b10;
   localparam logic [1:0] FIELD_HOUR = 2'b11;

   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return $clog2(m + 1);
   endfunction

   function automatic logic [1:0] field_code(input state_t s);
      logic [1:0] code;
      unique case (s)
         StRun:     code = FIELD_NONE;
         StSetSec:  code = FIELD_SEC;
         StSetMin:  code = FIELD_MIN;
         StSetHour: code = FIELD_HOUR;
         default:   code = FIELD_NONE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/btn_repeat.sv
// Press detector with hold-to-repeat for one debounced button level.
// o_event is combinational in the press/repeat cycle; the caller registers it.
module btn_repeat
   import watch_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY  = 50_000_000,
   parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   output logic o_event
);

   localparam int unsigned CW = cnt_width(REPEAT_DELAY, REPEAT_PERIOD, 1);
   localparam logic [CW-1:0] DELAY_C  = CW'(REPEAT_DELAY);
   localparam logic [CW-1:0] PERIOD_C = CW'(REPEAT_PERIOD);
   localparam logic [CW-1:0] ONE_C    = CW'(1);

   logic          btn_d;
   logic          armed_q;
   logic          rep_q;
   logic          rep_nxt;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_nxt;
   logic          press;
   logic          fire;

   // armed_q blocks a level that was already high when reset released
   assign press = i_btn & ~btn_d & armed_q;

   always_comb begin
      fire    = 1'b0;
      cnt_nxt = cnt_q;
      rep_nxt = rep_q;
      if (!i_btn) begin
         cnt_nxt = '0;
         rep_nxt = 1'b0;
      end else if (press) begin
         fire    = 1'b1;
         cnt_nxt = ONE_C;
         rep_nxt = 1'b0;
      end else if (cnt_q != '0) begin
         // cnt_q counts cycles since the last emitted event
         if (cnt_q == (rep_q ? PERIOD_C : DELAY_C)) begin
            fire    = 1'b1;
            cnt_nxt = ONE_C;
            rep_nxt = 1'b1;
         end else if (cnt_q != '1) begin
            cnt_nxt = cnt_q + ONE_C;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_d   <= 1'b0;
         armed_q <= 1'b0;
         rep_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         btn_d   <= i_btn;
         armed_q <= armed_q | ~i_btn;
         rep_q   <= rep_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   assign o_event = fire;

endmodule

// File: rtl/time_watch_set_ctrl.sv
// Setting-mode controller: field select FSM, up/down pulse routing with
// hold-to-repeat, and the blink strobe for the selected display field.
module time_watch_set_ctrl
   import watch_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY  = 50_000_000,
   parameter int unsigned REPEAT_PERIOD = 10_000_000,
   parameter int unsigned BLINK_HALF    = 25_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sw_setting,
   input  logic       btn_sel,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic       sec_up,
   output logic       min_up,
   output logic       hour_up,
   output logic       sec_down,
   output logic       min_down,
   output logic       hour_down,
   output logic [1:0] field_sel,
   output logic       blink
);

   localparam int unsigned CW = cnt_width(REPEAT_DELAY, REPEAT_PERIOD, BLINK_HALF);
   localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);

   state_t        state_q, state_d;
   logic          up_ev, down_ev;
   logic          sel_d, sel_armed_q, sel_press;
   logic          up_go, down_go;
   logic [2:0]    up_nxt, down_nxt, up_q, down_q;
   logic [1:0]    field_q;
   logic [CW-1:0] blink_cnt_q, blink_cnt_nxt;
   logic          blink_q, blink_nxt;

   btn_repeat #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_up (
      .clk     (clk),
      .reset   (reset),
      .i_btn   (btn_up),
      .o_event (up_ev)
   );

   btn_repeat #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_down (
      .clk     (clk),
      .reset   (reset),
      .i_btn   (btn_down),
      .o_event (down_ev)
   );

   assign sel_press = btn_sel & ~sel_d & sel_armed_q;
   assign up_go     = up_ev & ~down_ev & sw_setting;
   assign down_go   = down_ev & ~up_ev & sw_setting;

   always_comb begin
      state_d = state_q;
      if (!sw_setting) begin
         state_d = StRun;
      end else begin
         unique case (state_q)
            StRun:     state_d = StSetSec;
            StSetSec:  if (sel_press) state_d = StSetMin;
            StSetMin:  if (sel_press) state_d = StSetHour;
            StSetHour: if (sel_press) state_d = StSetSec;
            default:   state_d = StRun;
         endcase
      end
   end

   // Routed by the current state so a same-cycle select lands on the old field
   always_comb begin
      up_nxt   = '0;
      down_nxt = '0;
      unique case (state_q)
         StSetSec:  begin up_nxt[0] = up_go; down_nxt[0] = down_go; end
         StSetMin:  begin up_nxt[1] = up_go; down_nxt[1] = down_go; end
         StSetHour: begin up_nxt[2] = up_go; down_nxt[2] = down_go; end
         default:   begin end
      endcase
   end

   always_comb begin
      blink_cnt_nxt = blink_cnt_q + CW'(1);
      blink_nxt     = blink_q;
      if (state_d == StRun || state_q == StRun || (|up_nxt) || (|down_nxt)) begin
         blink_cnt_nxt = '0;
         blink_nxt     = 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_nxt = '0;
         blink_nxt     = ~blink_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StRun;
         sel_d       <= 1'b0;
         sel_armed_q <= 1'b0;
         up_q        <= '0;
         down_q      <= '0;
         field_q     <= FIELD_NONE;
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_d       <= btn_sel;
         sel_armed_q <= sel_armed_q | ~btn_sel;
         up_q        <= up_nxt;
         down_q      <= down_nxt;
         field_q     <= field_code(state_d);
         blink_cnt_q <= blink_cnt_nxt;
         blink_q     <= blink_nxt;
      end
   end

   assign sec_up    = up_q[0];
   assign min_up    = up_q[1];
   assign hour_up   = up_q[2];
   assign sec_down  = down_q[0];
   assign min_down  = down_q[1];
   assign hour_down = down_q[2];
   assign field_sel = field_q;
   assign blink     = blink_q;

endmodule

// File: tb/tb_time_watch_set_ctrl.sv
// Self-checking bench for time_watch_set_ctrl: directed scenarios plus random
// stimulus, compared every cycle against a hold-length based reference model.
module tb_time_watch_set_ctrl;

   localparam int RD = 8;
   localparam int RP = 4;
   localparam int BH = 5;

   logic       clk = 1'b0;
   logic       reset, sw_setting, btn_sel, btn_up, btn_down;
   logic       sec_up, min_up, hour_up, sec_down, min_down, hour_down, blink;
   logic [1:0] field_sel;

   always #5 clk = ~clk;

   time_watch_set_ctrl #(
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP),
      .BLINK_HALF    (BH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sw_setting (sw_setting),
      .btn_sel    (btn_sel),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .sec_up     (sec_up),
      .min_up     (min_up),
      .hour_up    (hour_up),
      .sec_down   (sec_down),
      .min_down   (min_down),
      .hour_down  (hour_down),
      .field_sel  (field_sel),
      .blink      (blink)
   );

   // Reference model: field 0 = none, 1..3 = sec/min/hour; m_h = cycles held since press.
   int         m_state;
   bit         m_prev [3];
   bit         m_armed[3];
   int         m_h    [2];
   int         m_bk;
   logic [5:0] exp_pulse;  // {hour_dn, min_dn, sec_dn, hour_up, min_up, sec_up}
   logic [1:0] exp_field;
   logic       exp_blink;

   always @(posedge clk) begin : model
      bit lvl[3];
      bit prs[3];
      bit ev [2];
      int nxt;
      bit en;
      lvl[0] = btn_up;
      lvl[1] = btn_down;
      lvl[2] = btn_sel;
      if (reset) begin
         m_state = 0;
         m_bk    = 0;
         for (int i = 0; i < 3; i++) begin m_prev[i] = 0; m_armed[i] = 0; end
         for (int i = 0; i < 2; i++) m_h[i] = -1;
         exp_pulse = '0;
         exp_field = 2'b00;
         exp_blink = 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            prs[i] = lvl[i] && !m_prev[i] && m_armed[i];
            if (!lvl[i]) m_armed[i] = 1;
            m_prev[i] = lvl[i];
         end
         for (int i = 0; i < 2; i++) begin
            if (!lvl[i]) m_h[i] = -1;
            else if (prs[i]) m_h[i] = 0;
            else if (m_h[i] >= 0) m_h[i] = m_h[i] + 1;
            ev[i] = (m_h[i] == 0) || (m_h[i] >= RD && ((m_h[i] - RD) % RP) == 0);
         end
         en = (m_state != 0) && sw_setting;
         exp_pulse = '0;
         if (en && ev[0] && !ev[1]) exp_pulse[m_state - 1] = 1'b1;
         if (en && ev[1] && !ev[0]) exp_pulse[m_state + 2] = 1'b1;
         if (!sw_setting) nxt = 0;
         else if (m_state == 0) nxt = 1;
         else if (prs[2]) nxt = (m_state == 3) ? 1 : m_state + 1;
         else nxt = m_state;
         if (nxt == 0 || m_state == 0 || exp_pulse != 0) m_bk = 0;
         else m_bk = m_bk + 1;
         exp_blink = (nxt != 0) && (((m_bk / BH) % 2) == 1);
         m_state   = nxt;
         exp_field = nxt[1:0];
      end
   end

   typedef struct {
      int cyc;
      int idx;
   } pev_t;

   int   n_chk  = 0;
   int   n_fail = 0;
   int   ncyc   = 0;
   pev_t plog[$];
   int   blink_chg[$];
   logic last_blink = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, ncyc);
      end
   endtask

   task automatic tick();
      logic [5:0] act;
      @(posedge clk);
      @(negedge clk);
      ncyc++;
      act = {hour_down, min_down, sec_down, hour_up, min_up, sec_up};
      check("pulses", 32'(act), 32'(exp_pulse));
      check("field_sel", 32'(field_sel), 32'(exp_field));
      check("blink", 32'(blink), 32'(exp_blink));
      for (int i = 0; i < 6; i++) if (act[i]) plog.push_back('{ncyc, i});
      if (blink !== last_blink) blink_chg.push_back(ncyc);
      last_blink = blink;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic int count_pulses(input int idx, input int from, input int to);
      int c = 0;
      foreach (plog[i])
         if (plog[i].cyc >= from && plog[i].cyc <= to && (idx < 0 || plog[i].idx == idx)) c++;
      return c;
   endfunction

   // Offset from 'from' of the n-th pulse (0-based) on output idx, or -1.
   function automatic int nth_pulse(input int idx, input int from, input int n);
      int k = 0;
      foreach (plog[i])
         if (plog[i].cyc > from && plog[i].idx == idx) begin
            if (k == n) return plog[i].cyc - from;
            k++;
         end
      return -1;
   endfunction

   function automatic int nth_blink_edge(input int from, input int n);
      int k = 0;
      foreach (blink_chg[i])
         if (blink_chg[i] > from) begin
            if (k == n) return blink_chg[i] - from;
            k++;
         end
      return -1;
   endfunction

   task automatic press_sel();
      btn_sel = 1'b1;
      tick();
      btn_sel = 1'b0;
      ticks(2);
   endtask

   initial begin
      int t0, t1;
      int offs[4];
      offs[0] = 1; offs[1] = 9; offs[2] = 13; offs[3] = 17;

      reset = 1'b1; sw_setting = 1'b0; btn_sel = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
      ticks(3);
      reset = 1'b0;
      ticks(2);

      // RUN: buttons must never produce pulses
      t0 = ncyc;
      btn_up = 1'b1; ticks(2); btn_up = 1'b0; ticks(2);
      btn_down = 1'b1; ticks(2); btn_down = 1'b0; ticks(3);
      check("run_no_pulse", 32'(count_pulses(-1, t0, ncyc)), 0);
      check("run_field", 32'(field_sel), 0);

      // Enter setting mode, single sec_up
      sw_setting = 1'b1;
      tick();
      check("enter_field", 32'(field_sel), 1);
      ticks(2);
      t0 = ncyc;
      btn_up = 1'b1; tick(); btn_up = 1'b0; ticks(4);
      check("sec_up_count", 32'(count_pulses(0, t0, ncyc)), 1);
      check("sec_up_latency", 32'(nth_pulse(0, t0, 0)), 1);

      // Select min then hour, single hour_down
      btn_sel = 1'b1; tick(); check("field_min", 32'(field_sel), 2); btn_sel = 1'b0; ticks(2);
      btn_sel = 1'b1; tick(); check("field_hour", 32'(field_sel), 3); btn_sel = 1'b0; ticks(2);
      t0 = ncyc;
      btn_down = 1'b1; tick(); btn_down = 1'b0; ticks(3);
      check("hour_down_count", 32'(count_pulses(5, t0, ncyc)), 1);
      check("hour_down_only", 32'(count_pulses(-1, t0, ncyc)), 1);

      // Hold-to-repeat in SET_MIN
      press_sel();
      press_sel();
      check("field_min2", 32'(field_sel), 2);
      t0 = ncyc;
      btn_up = 1'b1; ticks(20); btn_up = 1'b0; ticks(8);
      check("min_up_count", 32'(count_pulses(1, t0, ncyc)), 4);
      for (int k = 0; k < 4; k++) check("min_up_offset", 32'(nth_pulse(1, t0, k)), 32'(offs[k]));

      // Up and down together: discarded; up alone later repeats
      press_sel();
      press_sel();
      check("field_sec", 32'(field_sel), 1);
      t0 = ncyc;
      btn_up = 1'b1; btn_down = 1'b1; ticks(3);
      btn_down = 1'b0; ticks(7);
      btn_up = 1'b0; ticks(3);
      check("conflict_first_up", 32'(nth_pulse(0, t0, 0)), 9);
      check("conflict_up_count", 32'(count_pulses(0, t0, ncyc)), 1);
      check("conflict_no_down", 32'(count_pulses(3, t0, ncyc)), 0);

      // Drop sw_setting exactly where a repeat would land
      t0 = ncyc;
      btn_up = 1'b1; ticks(12);
      sw_setting = 1'b0; tick();
      t1 = ncyc;
      check("drop_field", 32'(field_sel), 0);
      check("drop_blink", 32'(blink), 0);
      ticks(5); btn_up = 1'b0; ticks(2);
      check("drop_before", 32'(count_pulses(0, t0, t1 - 1)), 2);
      check("drop_after", 32'(count_pulses(-1, t1, ncyc)), 0);

      // Idle in setting mode: blink toggles every BH cycles
      sw_setting = 1'b1;
      tick();
      t0 = ncyc;
      ticks(21);
      for (int k = 0; k < 4; k++) check("blink_edge", 32'(nth_blink_edge(t0, k)), 32'(BH * (k + 1)));

      // Randomized traffic, model-checked every cycle
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 39) == 0) sw_setting = ~sw_setting;
         reset = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 5) == 0) btn_up = ~btn_up;
         if ($urandom_range(0, 5) == 0) btn_down = ~btn_down;
         if ($urandom_range(0, 7) == 0) btn_sel = ~btn_sel;
         if ($urandom_range(0, 3) == 0 && btn_down) btn_down = btn_up;
         tick();
      end
      reset = 1'b0;
      ticks(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
